// File: rtl/instr_encode_loader.sv
// Encodes symbolic MIPS ops into 32-bit words and streams them into instruction
// memory, one word per two cycles, with a sequential write pointer and fill count.
module instr_encode_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic              flush,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy
);

  typedef enum logic [2:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_LW, OP_SW, OP_BEQ
  } op_e;

  typedef enum logic {S_IDLE, S_WRITE} state_e;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_we;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         w_word;
  logic                w_full;
  logic                w_accept;

  always_comb begin
    w_word = 32'h0;
    case (op_e'(req_op))
      OP_ADD:  w_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100000};
      OP_ADDU: w_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100001};
      OP_SUB:  w_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100010};
      OP_SUBU: w_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100011};
      OP_AND:  w_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100100};
      OP_LW:   w_word = {6'b100011, req_rs, req_rt, req_imm};
      OP_SW:   w_word = {6'b101011, req_rs, req_rt, req_imm};
      OP_BEQ:  w_word = {6'b000100, req_rs, req_rt, req_imm};
      default: w_word = 32'h0;
    endcase
  end

  assign w_full    = (r_count == DEPTH);
  assign req_ready = (r_state == S_IDLE) && !w_full && !flush && !reset;
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_ptr   <= '0;
            r_count <= '0;
          end else if (w_accept) begin
            r_addr  <= r_ptr;
            r_wdata <= w_word;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          // The memory captures the word on this edge; a flush here only
          // rewinds the pointer, it does not cancel the write.
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (flush) begin
            r_ptr   <= '0;
            r_count <= '0;
          end else begin
            r_ptr   <= r_ptr + ADDR_W'(1);
            r_count <= r_count + (ADDR_W+1)'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_we    = r_we;
  assign busy       = r_busy;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign full       = w_full;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: inputs driven and outputs sampled on
// the falling edge; a posedge write log stands in for the instruction memory.
module tb_instr_encode_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [4:0]        req_rs, req_rt, req_rd;
  logic [15:0]       req_imm;
  logic              flush;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;

  int          wr_cnt = 0;
  logic [5:0]  log_addr [0:255];
  logic [31:0] log_data [0:255];

  instr_encode_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm(req_imm), .flush(flush), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .full(full), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we && wr_cnt < 256) begin
      log_addr[wr_cnt] <= imem_addr;
      log_data[wr_cnt] <= imem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Stimulus helper only: one-cycle request, returns at the negedge after the write cycle.
  task automatic issue(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm);
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; flush = 1'b0;
    req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({imem_we, imem_addr, imem_wdata, count, full, busy, req_ready} !== 48'h0)
      $display("FAIL reset_outputs: got we=%0b addr=%0d wdata=%h count=%0d full=%0b busy=%0b rdy=%0b, want all 0",
               imem_we, imem_addr, imem_wdata, count, full, busy, req_ready);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b want 1", req_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_add();
    req_op = 3'd0; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd3; req_imm = 16'h0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (imem_we !== 1'b1 || busy !== 1'b1 || imem_addr !== 6'd0 || imem_wdata !== 32'h00221820)
      $display("FAIL add_write: got we=%0b busy=%0b addr=%0d wdata=%h, want 1 1 0 00221820",
               imem_we, busy, imem_addr, imem_wdata);
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b0 || count !== 7'd0)
      $display("FAIL add_during_write: got rdy=%0b count=%0d, want 0 0", req_ready, count);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (imem_we !== 1'b0 || count !== 7'd1 || imem_wdata !== 32'h00221820)
      $display("FAIL add_after: got we=%0b count=%0d wdata=%h, want 0 1 00221820 (held)",
               imem_we, count, imem_wdata);
    else n_pass++;
  endtask

  task automatic test_itype();
    int base;
    do_flush();
    base = wr_cnt;
    issue(3'd5, 5'd0,  5'd8,  5'd31, 16'h0004);
    issue(3'd6, 5'd29, 5'd31, 5'd17, 16'hFFFC);
    issue(3'd7, 5'd1,  5'd2,  5'd9,  16'hFFFF);
    n_checks++;
    if (wr_cnt - base !== 3 || count !== 7'd3)
      $display("FAIL itype_count: got writes=%0d count=%0d, want 3 3", wr_cnt - base, count);
    else n_pass++;
    n_checks++;
    if (log_addr[base] !== 6'd0 || log_data[base] !== 32'h8C080004)
      $display("FAIL itype_lw: got addr=%0d data=%h, want 0 8C080004", log_addr[base], log_data[base]);
    else n_pass++;
    n_checks++;
    if (log_addr[base+1] !== 6'd1 || log_data[base+1] !== 32'hAFBFFFFC)
      $display("FAIL itype_sw: got addr=%0d data=%h, want 1 AFBFFFFC", log_addr[base+1], log_data[base+1]);
    else n_pass++;
    n_checks++;
    if (log_addr[base+2] !== 6'd2 || log_data[base+2] !== 32'h1022FFFF)
      $display("FAIL itype_beq: got addr=%0d data=%h, want 2 1022FFFF", log_addr[base+2], log_data[base+2]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int base;
    logic [5:0] rdy_seen;
    do_flush();
    base = wr_cnt;
    req_op = 3'd3; req_rs = 5'd4; req_rt = 5'd5; req_rd = 5'd6; req_imm = 16'h1234;
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rdy_seen[5-i] = req_ready;
      if (i == 5) req_valid = 1'b0;
      else @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (rdy_seen !== 6'b101010) $display("FAIL b2b_ready_pattern: got %b want 101010", rdy_seen);
    else n_pass++;
    n_checks++;
    if (wr_cnt - base !== 3 || count !== 7'd3)
      $display("FAIL b2b_count: got writes=%0d count=%0d, want 3 3", wr_cnt - base, count);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (log_addr[base+i] !== 6'(i) || log_data[base+i] !== 32'h00853023)
        $display("FAIL b2b_write%0d: got addr=%0d data=%h, want %0d 00853023",
                 i, log_addr[base+i], log_data[base+i], i);
      else n_pass++;
    end
  endtask

  task automatic test_full();
    int base;
    do_flush();
    base = wr_cnt;
    for (int i = 0; i < 64; i++) issue(3'd4, 5'(i), 5'd7, 5'(i + 3), 16'h0);
    n_checks++;
    if (count !== 7'd64 || full !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL full_state: got count=%0d full=%0b rdy=%0b, want 64 1 0", count, full, req_ready);
    else n_pass++;
    n_checks++;
    // last word: AND rs=31 rt=7 rd=(63+3)%32=2
    if (log_addr[base+63] !== 6'd63 || log_data[base+63] !== {6'b0, 5'd31, 5'd7, 5'd2, 5'b0, 6'b100100})
      $display("FAIL full_last_word: got addr=%0d data=%h", log_addr[base+63], log_data[base+63]);
    else n_pass++;
    base = wr_cnt;
    req_valid = 1'b1;
    repeat (10) @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (wr_cnt !== base || count !== 7'd64)
      $display("FAIL full_blocks: got writes=%0d count=%0d, want 0 64", wr_cnt - base, count);
    else n_pass++;
    do_flush();
    n_checks++;
    if (count !== 7'd0 || full !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL full_flush: got count=%0d full=%0b rdy=%0b, want 0 0 1", count, full, req_ready);
    else n_pass++;
    issue(3'd1, 5'd9, 5'd10, 5'd11, 16'h0);
    n_checks++;
    if (log_addr[base] !== 6'd0 || log_data[base] !== 32'h012A5821 || count !== 7'd1)
      $display("FAIL full_rewrite: got addr=%0d data=%h count=%0d, want 0 012A5821 1",
               log_addr[base], log_data[base], count);
    else n_pass++;
  endtask

  task automatic test_flush_idle();
    int base;
    base = wr_cnt;
    req_op = 3'd0; req_rs = 5'd1; req_rt = 5'd1; req_rd = 5'd1;
    flush = 1'b1; req_valid = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL flush_idle_ready: got %0b want 0", req_ready);
    else n_pass++;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_cnt !== base || imem_we !== 1'b0 || count !== 7'd0)
      $display("FAIL flush_idle_noaccept: got writes=%0d we=%0b count=%0d, want 0 0 0",
               wr_cnt - base, imem_we, count);
    else n_pass++;
  endtask

  task automatic test_flush_write();
    int base;
    issue(3'd2, 5'd3, 5'd4, 5'd5, 16'h0);
    base = wr_cnt;
    req_op = 3'd0; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd3;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (wr_cnt - base !== 1 || log_addr[base] !== 6'd1 || log_data[base] !== 32'h00221820 || count !== 7'd0)
      $display("FAIL flush_write: got writes=%0d addr=%0d data=%h count=%0d, want 1 1 00221820 0",
               wr_cnt - base, log_addr[base], log_data[base], count);
    else n_pass++;
    issue(3'd5, 5'd2, 5'd3, 5'd0, 16'h0010);
    n_checks++;
    if (log_addr[base+1] !== 6'd0 || log_data[base+1] !== 32'h8C430010)
      $display("FAIL flush_write_next: got addr=%0d data=%h, want 0 8C430010",
               log_addr[base+1], log_data[base+1]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int base;
    req_op = 3'd0; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd3;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (imem_we !== 1'b1) $display("FAIL areset_pre: got we=%0b want 1", imem_we);
    else n_pass++;
    base = wr_cnt;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (imem_we !== 1'b0 || busy !== 1'b0 || count !== 7'd0)
      $display("FAIL areset_immediate: got we=%0b busy=%0b count=%0d, want 0 0 0", imem_we, busy, count);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || wr_cnt !== base)
      $display("FAIL areset_release: got rdy=%0b writes=%0d, want 1 0", req_ready, wr_cnt - base);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_itype();
    test_back_to_back();
    test_full();
    test_flush_idle();
    test_flush_write();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
